// File: rtl/req_arb_pkg.sv
// Shared definitions for the two-master req-bus arbiter.
package req_arb_pkg;

    // Arbiter state: waiting, request handshake, data beats.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // Master indices; M0 is the CPU path, M1 the DMA requester.
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Default width of req_len (beats minus one).
    localparam int LEN_W_DEF = 3;

endpackage

// File: rtl/req_arb_if.sv
// One req-bus port: request handshake, write beats and read beats.
// "master" is the requester side; "slave" is the side that serves it.
interface req_arb_if
    import req_arb_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
) ();
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [LEN_W-1:0] req_len;
    logic [3:0]       req_mask;
    logic [31:0]      req_addr;
    logic             write_valid;
    logic [31:0]      write_data;
    logic             read_valid;
    logic [31:0]      read_data;
    logic             read_ack;

    modport master (
        output req_valid, input  req_ready, output req_we,
        output req_len,   output req_mask,  output req_addr,
        output write_valid, output write_data,
        input  read_valid,  input  read_data, output read_ack
    );

    modport slave (
        input  req_valid, output req_ready, input  req_we,
        input  req_len,   input  req_mask,  input  req_addr,
        input  write_valid, input  write_data,
        output read_valid,  output read_data, input  read_ack
    );
endinterface

// File: rtl/req_arb_pick.sv
// Winner select for a new grant: a lone requester always wins; on a tie
// round-robin hands the bus to whoever did not own it last, while fixed
// priority always picks M0.
module req_arb_pick
    import req_arb_pkg::*;
#(
    parameter bit RR = 1'b1
) (
    input  logic [1:0] valid,
    input  logic       last,
    output logic       winner
);

    // Combinational winner for the IDLE grant edge.
    always_comb begin
        winner = M0;
        if (valid == 2'b10) begin
            winner = M1;
        end else if (valid == 2'b11 && RR) begin
            winner = ~last;
        end
    end

endmodule

// File: rtl/req_arb.sv
// Two-master arbiter in front of the shared req-bus slave. The grant is held
// from request handshake through the final data beat; all bus outputs are
// combinational muxes of the registered grant and state.
module req_arb
    import req_arb_pkg::*;
#(
    parameter bit RR    = 1'b1,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic         clk_i,
    input  logic         rst_i,
    req_arb_if.slave     m0,
    req_arb_if.slave     m1,
    req_arb_if.master    s
);

    state_t           state_q, state_d;
    logic             grant_q, grant_d;
    logic             last_q,  last_d;
    logic [LEN_W:0]   beats_q, beats_d;
    logic             we_q,    we_d;

    logic             winner;

    logic             g_req_valid;
    logic             g_req_we;
    logic [LEN_W-1:0] g_req_len;
    logic [3:0]       g_req_mask;
    logic [31:0]      g_req_addr;
    logic             g_write_valid;
    logic [31:0]      g_write_data;
    logic             g_read_ack;

    logic             in_req;
    logic             in_data;
    logic             rd_path;
    logic             req_hs;
    logic             wr_beat;
    logic             rd_beat;
    logic [LEN_W:0]   len_beats;

    req_arb_pick #(.RR(RR)) u_pick (
        .valid  ({m1.req_valid, m0.req_valid}),
        .last   (last_q),
        .winner (winner)
    );

    // Select the granted master's request-side signals.
    always_comb begin
        if (grant_q == M1) begin
            g_req_valid   = m1.req_valid;
            g_req_we      = m1.req_we;
            g_req_len     = m1.req_len;
            g_req_mask    = m1.req_mask;
            g_req_addr    = m1.req_addr;
            g_write_valid = m1.write_valid;
            g_write_data  = m1.write_data;
            g_read_ack    = m1.read_ack;
        end else begin
            g_req_valid   = m0.req_valid;
            g_req_we      = m0.req_we;
            g_req_len     = m0.req_len;
            g_req_mask    = m0.req_mask;
            g_req_addr    = m0.req_addr;
            g_write_valid = m0.write_valid;
            g_write_data  = m0.write_data;
            g_read_ack    = m0.read_ack;
        end
    end

    // Handshake qualifiers. A write beat on the request-accept cycle counts.
    always_comb begin
        in_req    = (state_q == ST_REQ);
        in_data   = (state_q == ST_DATA);
        rd_path   = in_data & ~we_q;
        req_hs    = in_req & g_req_valid & s.req_ready;
        wr_beat   = g_write_valid & ((in_data & we_q) | (req_hs & g_req_we));
        rd_beat   = rd_path & s.read_valid & g_read_ack;
        len_beats = {1'b0, g_req_len} + (LEN_W+1)'(1);
    end

    // Slave-side bus: only driven while a transaction is in flight.
    always_comb begin
        s.req_valid   = in_req & g_req_valid;
        s.req_we      = in_req & g_req_we;
        s.req_len     = in_req ? g_req_len  : '0;
        s.req_mask    = in_req ? g_req_mask : '0;
        s.req_addr    = in_req ? g_req_addr : '0;
        s.write_valid = wr_beat;
        s.write_data  = wr_beat ? g_write_data : '0;
        s.read_ack    = rd_path & g_read_ack;
    end

    // Master-side returns: a non-granted master sees all zeros.
    always_comb begin
        m0.req_ready  = in_req & (grant_q == M0) & s.req_ready;
        m1.req_ready  = in_req & (grant_q == M1) & s.req_ready;
        m0.read_valid = rd_path & (grant_q == M0) & s.read_valid;
        m1.read_valid = rd_path & (grant_q == M1) & s.read_valid;
        m0.read_data  = (rd_path && grant_q == M0) ? s.read_data : '0;
        m1.read_data  = (rd_path && grant_q == M1) ? s.read_data : '0;
    end

    // Next-state: grant in IDLE, latch length/direction in REQ, count beats in DATA.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        beats_d = beats_q;
        we_d    = we_q;
        case (state_q)
            ST_IDLE: begin
                if (m0.req_valid || m1.req_valid) begin
                    grant_d = winner;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (req_hs) begin
                    we_d = g_req_we;
                    if (wr_beat) begin
                        beats_d = len_beats - (LEN_W+1)'(1);
                    end else begin
                        beats_d = len_beats;
                    end
                    // A single-beat write can finish on the accept cycle itself.
                    if (wr_beat && len_beats == (LEN_W+1)'(1)) begin
                        last_d  = grant_q;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (wr_beat || rd_beat) begin
                    beats_d = beats_q - (LEN_W+1)'(1);
                    if (beats_q == (LEN_W+1)'(1)) begin
                        last_d  = grant_q;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset leaves M0 ahead for the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= M0;
            last_q  <= M1;
            beats_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            beats_q <= beats_d;
            we_q    <= we_d;
        end
    end

endmodule

// File: tb/tb_req_arb.sv
// Self-checking bench for req_arb: a round-robin instance carries most of the
// traffic, a fixed-priority instance checks M0 dominance. Expected grants,
// write beats and read beats go into queues as stimulus is driven and are
// popped by negedge monitors when the arbiter produces them.
module tb_req_arb;
    import req_arb_pkg::*;

    localparam int LEN_W = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    req_arb_if #(.LEN_W(LEN_W)) m0 ();
    req_arb_if #(.LEN_W(LEN_W)) m1 ();
    req_arb_if #(.LEN_W(LEN_W)) s  ();
    req_arb_if #(.LEN_W(LEN_W)) f0 ();
    req_arb_if #(.LEN_W(LEN_W)) f1 ();
    req_arb_if #(.LEN_W(LEN_W)) fs ();

    req_arb #(.RR(1'b1), .LEN_W(LEN_W)) dut (
        .clk_i (clk), .rst_i (rst), .m0 (m0), .m1 (m1), .s (s)
    );

    req_arb #(.RR(1'b0), .LEN_W(LEN_W)) dut_fp (
        .clk_i (clk), .rst_i (rst), .m0 (f0), .m1 (f1), .s (fs)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int wr_seen = 0;
    bit t1_watch = 1'b0;

    logic [31:0] gq[$];
    logic [31:0] wq[$];
    logic [32:0] rq[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit idx, input bit v, input bit we,
                           input logic [LEN_W-1:0] len, input logic [31:0] addr);
        if (idx == 1'b0) begin
            m0.req_valid = v; m0.req_we = we; m0.req_len = len;
            m0.req_mask = 4'hF; m0.req_addr = addr;
        end else begin
            m1.req_valid = v; m1.req_we = we; m1.req_len = len;
            m1.req_mask = 4'hF; m1.req_addr = addr;
        end
    endtask

    task automatic set_ack(input bit idx, input bit a);
        if (idx == 1'b0) m0.read_ack = a;
        else m1.read_ack = a;
    endtask

    function automatic logic rdy(input bit idx);
        return idx ? m1.req_ready : m0.req_ready;
    endfunction

    // Raise a request, wait (bounded) for acceptance, then drop it.
    task automatic do_req(input bit idx, input bit we, input logic [LEN_W-1:0] len,
                          input logic [31:0] addr);
        bit got;
        got = 1'b0;
        set_req(idx, 1'b1, we, len, addr);
        gq.push_back(addr);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (rdy(idx)) begin
                got = 1'b1;
                break;
            end
        end
        chk("req_wait", 64'(got), 64'd1);
        tick();
        set_req(idx, 1'b0, 1'b0, '0, '0);
    endtask

    // Feed n read beats from the slave, withholding the master ack for hold cycles each.
    task automatic read_beats(input bit idx, input int n, input int hold, input logic [31:0] base);
        for (int b = 0; b < n; b++) begin
            s.read_valid = 1'b1;
            s.read_data  = base + 32'(b);
            rq.push_back({idx, base + 32'(b)});
            for (int w = 0; w < hold; w++) begin
                set_ack(idx, 1'b0);
                @(negedge clk);
                chk("rack_hold", 64'(s.read_ack), 64'd0);
                chk("grant_held", 64'(dut.state_q), 64'(ST_DATA));
                tick();
            end
            set_ack(idx, 1'b1);
            @(negedge clk);
            chk("rack_follow", 64'(s.read_ack), 64'd1);
            tick();
        end
        s.read_valid = 1'b0;
        s.read_data  = '0;
        set_ack(idx, 1'b0);
    endtask

    // Monitors: grants, forwarded write beats, delivered read beats.
    always @(negedge clk) begin
        if (!rst) begin
            if (s.req_valid && s.req_ready) begin
                if (gq.size() == 0) chk("grant_extra", 64'(gq.size()), 64'd1);
                else chk("grant_addr", 64'(s.req_addr), 64'(gq.pop_front()));
            end
            if (s.write_valid) begin
                wr_seen++;
                if (wq.size() == 0) chk("wr_extra", 64'(wq.size()), 64'd1);
                else chk("wr_data", 64'(s.write_data), 64'(wq.pop_front()));
            end
            if (m0.read_valid && m0.read_ack) begin
                if (rq.size() == 0) chk("rd0_extra", 64'(rq.size()), 64'd1);
                else chk("rd0_data", 64'({1'b0, m0.read_data}), 64'(rq.pop_front()));
            end
            if (m1.read_valid && m1.read_ack) begin
                if (rq.size() == 0) chk("rd1_extra", 64'(rq.size()), 64'd1);
                else chk("rd1_data", 64'({1'b1, m1.read_data}), 64'(rq.pop_front()));
            end
            if (t1_watch) begin
                chk("m1_quiet", 64'({m1.req_ready, m1.read_valid, m1.read_data}), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        rst = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        m0.write_valid = 1'b0; m0.write_data = '0; m0.read_ack = 1'b0;
        m1.write_valid = 1'b0; m1.write_data = '0; m1.read_ack = 1'b0;
        s.req_ready = 1'b1; s.read_valid = 1'b0; s.read_data = '0;
        f0.req_valid = 1'b0; f0.req_we = 1'b0; f0.req_len = '0; f0.req_mask = 4'hF;
        f0.req_addr = '0; f0.write_valid = 1'b0; f0.write_data = '0; f0.read_ack = 1'b0;
        f1.req_valid = 1'b0; f1.req_we = 1'b0; f1.req_len = '0; f1.req_mask = 4'hF;
        f1.req_addr = '0; f1.write_valid = 1'b0; f1.write_data = '0; f1.read_ack = 1'b0;
        fs.req_ready = 1'b1; fs.read_valid = 1'b0; fs.read_data = '0;

        // Reset state.
        tick();
        tick();
        @(negedge clk);
        chk("rst_state", 64'(dut.state_q), 64'(ST_IDLE));
        chk("rst_grant", 64'(dut.grant_q), 64'(M0));
        chk("rst_last",  64'(dut.last_q),  64'(M1));
        chk("rst_outs", 64'({s.req_valid, s.write_valid, s.read_ack, m0.req_ready,
                             m1.req_ready, m0.read_valid, m1.read_valid}), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // M0 single read, minimum latency.
        t1_watch = 1'b1;
        set_req(1'b0, 1'b1, 1'b0, 3'd0, 32'h0000_1000);
        gq.push_back(32'h0000_1000);
        @(negedge clk);
        chk("lat_pre", 64'(s.req_valid), 64'd0);
        @(negedge clk);
        chk("lat_req", 64'(s.req_valid), 64'd1);
        chk("lat_ready", 64'(m0.req_ready), 64'd1);
        tick();
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        s.read_valid = 1'b1; s.read_data = 32'hDEAD_BEEF; m0.read_ack = 1'b1;
        rq.push_back({1'b0, 32'hDEAD_BEEF});
        @(negedge clk);
        chk("t1_rdata", 64'(m0.read_data), 64'hDEAD_BEEF);
        tick();
        s.read_valid = 1'b0; s.read_data = '0; m0.read_ack = 1'b0;
        @(negedge clk);
        chk("t1_idle", 64'(dut.state_q), 64'(ST_IDLE));
        t1_watch = 1'b0;
        tick();

        // M1 write burst, first beat on the request-accept cycle.
        wr_seen = 0;
        set_req(1'b1, 1'b1, 1'b1, 3'd3, 32'h0000_2000);
        gq.push_back(32'h0000_2000);
        tick();
        m1.write_valid = 1'b1; m1.write_data = 32'h11; wq.push_back(32'h11);
        @(negedge clk);
        chk("wr_hs_ready", 64'(m1.req_ready), 64'd1);
        tick();
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        for (int b = 2; b <= 4; b++) begin
            m1.write_data = 32'(b * 32'h11);
            wq.push_back(32'(b * 32'h11));
            tick();
        end
        m1.write_valid = 1'b0;
        @(negedge clk);
        chk("wr_count", 64'(wr_seen), 64'd4);
        chk("wr_idle", 64'(dut.state_q), 64'(ST_IDLE));
        // A stray write strobe in IDLE must not reach the slave.
        tick();
        m1.write_valid = 1'b1; m1.write_data = 32'h55;
        tick();
        m1.write_valid = 1'b0;
        tick();

        // M1 read burst with withheld acks; M0 strays meanwhile.
        do_req(1'b1, 1'b0, 3'd3, 32'h0000_3000);
        m0.write_valid = 1'b1; m0.write_data = 32'hBAD0; m0.read_ack = 1'b1;
        read_beats(1'b1, 4, 2, 32'hA0);
        m0.write_valid = 1'b0; m0.read_ack = 1'b0;
        @(negedge clk);
        chk("rb_idle", 64'(dut.state_q), 64'(ST_IDLE));
        chk("rb_last", 64'(dut.last_q), 64'(M1));
        tick();

        // Round-robin: both masters request continuously for 6 rounds.
        set_req(1'b0, 1'b1, 1'b0, 3'd0, 32'h0000_4000);
        set_req(1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_5000);
        for (int r = 0; r < 6; r++) gq.push_back((r % 2 == 0) ? 32'h0000_4000 : 32'h0000_5000);
        for (int r = 0; r < 6; r++) begin
            got = 1'b0;
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                if (s.req_valid) begin
                    got = 1'b1;
                    break;
                end
            end
            chk("rr_wait", 64'(got), 64'd1);
            tick();
            if (r == 5) begin
                set_req(1'b0, 1'b0, 1'b0, '0, '0);
                set_req(1'b1, 1'b0, 1'b0, '0, '0);
            end
            s.read_valid = 1'b1; s.read_data = 32'hC0 + 32'(r);
            m0.read_ack = 1'b1; m1.read_ack = 1'b1;
            rq.push_back({1'(r % 2), 32'hC0 + 32'(r)});
            @(negedge clk);
            chk("rr_loser_rv", 64'((r % 2 == 0) ? m1.read_valid : m0.read_valid), 64'd0);
            tick();
            s.read_valid = 1'b0; m0.read_ack = 1'b0; m1.read_ack = 1'b0;
        end
        @(negedge clk);
        chk("rr_idle", 64'(dut.state_q), 64'(ST_IDLE));
        tick();

        // Fixed priority: M0 wins every round while it keeps requesting.
        f0.req_valid = 1'b1; f0.req_addr = 32'h0000_6000;
        f1.req_valid = 1'b1; f1.req_addr = 32'h0000_7000;
        for (int r = 0; r < 7; r++) begin
            got = 1'b0;
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                if (fs.req_valid) begin
                    got = 1'b1;
                    break;
                end
            end
            chk("fp_wait", 64'(got), 64'd1);
            chk("fp_grant", 64'(fs.req_addr), (r < 6) ? 64'h6000 : 64'h7000);
            chk("fp_loser_rdy", 64'((r < 6) ? f1.req_ready : f0.req_ready), 64'd0);
            tick();
            if (r == 5) f0.req_valid = 1'b0;
            if (r == 6) f1.req_valid = 1'b0;
            fs.read_valid = 1'b1; fs.read_data = 32'hE0 + 32'(r);
            f0.read_ack = 1'b1; f1.read_ack = 1'b1;
            @(negedge clk);
            chk("fp_rdata", 64'((r < 6) ? f0.read_data : f1.read_data), 64'hE0 + 64'(r));
            tick();
            fs.read_valid = 1'b0; f0.read_ack = 1'b0; f1.read_ack = 1'b0;
        end
        tick();

        // Reset mid-burst after 2 of 4 beats, then a fresh M0 request.
        do_req(1'b0, 1'b0, 3'd3, 32'h0000_8000);
        read_beats(1'b0, 2, 0, 32'h90);
        s.read_valid = 1'b1; s.read_data = 32'h92;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        s.read_valid = 1'b0; s.read_data = '0;
        @(negedge clk);
        chk("rstm_state", 64'(dut.state_q), 64'(ST_IDLE));
        chk("rstm_outs", 64'({s.req_valid, s.write_valid, s.read_ack, m0.req_ready,
                              m1.req_ready, m0.read_valid, m1.read_valid}), 64'd0);
        tick();
        do_req(1'b0, 1'b0, 3'd0, 32'h0000_9000);
        read_beats(1'b0, 1, 0, 32'hF0);
        @(negedge clk);
        chk("fresh_idle", 64'(dut.state_q), 64'(ST_IDLE));

        chk("gq_empty", 64'(gq.size()), 64'd0);
        chk("wq_empty", 64'(wq.size()), 64'd0);
        chk("rq_empty", 64'(rq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/req_arb.md
Name: req_arb

Overview:
- Two-master arbiter for the shared req-bus that feeds req_sdram.
- Master 0 is the CPU path, after req_mux. Master 1 is a DMA requester, e.g. a VGA framebuffer fetch.
- Grants one master at a time and holds the grant for the whole transaction: request handshake plus all data beats.
- Muxes the request, write data and read data between the granted master and the single slave port.

Parameters:
- RR, 1: 1 = round-robin between masters; 0 = fixed priority, master 0 wins.
- LEN_W, 3: width of req_len; transaction beat count = req_len + 1.

Ports:
- clk_i  in  1  system clock (sys_clk)
- rst_i  in  1  synchronous active-high reset
- mN_req_valid  in  1  master N request valid (N = 0, 1)
- mN_req_ready  out  1  request accepted by slave
- mN_req_we  in  1  write transaction
- mN_req_len  in  LEN_W  beats minus one
- mN_req_mask  in  4  byte mask
- mN_req_addr  in  32  byte address
- mN_write_valid  in  1  write beat strobe
- mN_write_data  in  32  write beat data
- mN_read_valid  out  1  read beat available
- mN_read_data  out  32  read beat data
- mN_read_ack  in  1  read beat consumed
- s_req_valid / s_req_ready / s_req_we / s_req_len / s_req_mask / s_req_addr: out/in/out/out/out/out, widths as above; slave request bus
- s_write_valid  out  1  write beat strobe to slave
- s_write_data  out  32  write beat data to slave
- s_read_valid  in  1  read beat from slave
- s_read_data  in  32  read beat data from slave
- s_read_ack  out  1  read beat consumed

Behaviour:
- Reset values: all *_valid, *_ready and s_read_ack outputs 0; state IDLE; grant = M0; last = M1, so M0 wins the first tie.
- Outputs are combinational muxes of the registered grant. A non-granted master sees req_ready = 0, read_valid = 0, read_data = 0. A non-granted master's write_valid and read_ack are ignored.
- State IDLE:
  - If either mN_req_valid is set, choose a winner and register grant. Go to REQ.
  - Tie, RR=1: winner = master != last. Tie, RR=0: M0.
  - No slave signals are driven in IDLE. Minimum request latency: mN_req_valid high at edge k -> s_req_valid high during cycle k+1.
- State REQ:
  - s_req_* = granted master's req_*; mN_req_ready = s_req_ready.
  - On s_req_valid & s_req_ready: latch beats = len + 1 and we. Go to DATA.
  - A master must not drop req_valid before ready; the arbiter does not re-arbitrate in REQ.
- State DATA, write:
  - s_write_valid/data = granted master's write_valid/data. Decrement beats per s_write_valid.
  - A write beat presented in the same cycle as the request handshake in REQ is also forwarded and counted.
- State DATA, read:
  - Granted mN_read_valid/data = s_read_valid/data; s_read_ack = mN_read_ack.
  - Decrement beats per s_read_valid & s_read_ack.
- DATA exit: when the final beat completes (beats == 1 and the beat handshake fires), update last = grant and go to IDLE. The next grant decision happens in IDLE on the following edge. Turnaround is one idle cycle.
- Beat counter is LEN_W+1 bits wide. len = 7 -> 8 beats, no overflow. len = 0 -> single beat.
- Extra write_valid/read_ack pulses outside DATA/REQ are ignored, never forwarded.
- A master deasserting req_valid while in IDLE before the grant edge is not tracked; requests are sampled only at the grant edge.
- rst_i mid-transaction: return to IDLE with reset values next cycle. The slave shares rst_i, so no partial-transaction recovery is required.

Decomposition:
- Shared package/header:
  - state encoding IDLE/REQ/DATA (2 bits)
  - master index constants M0/M1
  - LEN_W default
- Optional sub-module req_arb_pick: combinational winner select (inputs: valids, last, RR; output: winner index). Everything else stays in req_arb.

Test Plan:
- M0 single read, len = 0, addr 0x00001000:
  - s_req_valid rises 1 cycle after m0_req_valid.
  - One s_read_valid & m0_read_ack beat with data 0xDEADBEEF reaches m0_read_data.
  - Returns to IDLE; m1 outputs stay 0 throughout.
- M1 write burst, len = 3, data 0x11..0x44, first beat presented on the request-accept cycle: exactly 4 s_write_valid pulses with matching data, then IDLE.
- Simultaneous m0/m1 requests, RR = 1, 6 back-to-back rounds:
  - Grants alternate M0, M1, M0, M1, ...
  - With RR = 0, M0 wins all 6 while m0_req_valid stays high.
- Read burst len = 3 with m1_read_ack withheld 2 cycles per beat: s_read_ack follows m1_read_ack; no beat lost or duplicated; grant held until the 4th ack.
- Stray m0_write_valid and m0_read_ack while M1 owns the bus: no effect on s_write_valid, s_read_ack or the beat count.
- rst_i asserted for 1 cycle mid-burst after 2 of 4 beats: next cycle all outputs 0, state IDLE; a fresh M0 request is then granted normally.
